// File: rtl/pixel_stream_gen.sv
// Raster pixel source: frames of IMAGE_WIDTH x IMAGE_HEIGHT over valid/ready with sof/eol/eof.
// Optional inter-line idle gap compiled in with `define PIXEL_GEN_LINE_GAP_EN.
module pixel_stream_gen #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 420,
  parameter int unsigned NUM_FRAMES   = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] CONST_VALUE  = 16'h0080,
  parameter int unsigned GAP_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count
);

  localparam int unsigned CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
`ifdef PIXEL_GEN_LINE_GAP_EN
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GW-1:0] r_gap_cnt;
`endif

  logic [1:0]            r_state;
  logic [1:0]            r_mode;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [15:0]           r_lfsr;
  logic [15:0]           r_frame_count;
  logic                  r_done;

  logic                  w_valid;
  logic                  w_xfer;
  logic                  w_eol;
  logic                  w_eof;
  logic                  w_last;
  logic [15:0]           w_lfsr_next;
  logic [DATA_WIDTH-1:0] w_pix;

  assign w_valid     = (r_state == ST_STREAM);
  assign w_xfer      = w_valid && pixel_ready;
  assign w_eol       = (r_col == COL_LAST);
  assign w_eof       = w_eol && (r_row == ROW_LAST);
  // Run ends on the eof transfer that brings the count up to NUM_FRAMES.
  assign w_last      = w_xfer && w_eof && (NUM_FRAMES != 0) &&
                       ((r_frame_count + 16'd1) == 16'(NUM_FRAMES));
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_mode        <= 2'd0;
      r_col         <= '0;
      r_row         <= '0;
      r_lfsr        <= LFSR_SEED;
      r_frame_count <= 16'd0;
      r_done        <= 1'b0;
`ifdef PIXEL_GEN_LINE_GAP_EN
      r_gap_cnt     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state       <= ST_STREAM;
            r_mode        <= mode;
            r_col         <= '0;
            r_row         <= '0;
            r_frame_count <= 16'd0;
            r_lfsr        <= LFSR_SEED;
          end
        end
        ST_STREAM: begin
          if (w_xfer) begin
            r_lfsr <= w_lfsr_next;
            if (w_eol) begin
              r_col <= '0;
              r_row <= w_eof ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_eof) r_frame_count <= r_frame_count + 16'd1;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
`ifdef PIXEL_GEN_LINE_GAP_EN
            else if (w_eol && (GAP_CYCLES != 0)) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GW'(GAP_CYCLES - 1);
            end
`endif
          end
        end
`ifdef PIXEL_GEN_LINE_GAP_EN
        ST_GAP: begin
          if (r_gap_cnt == '0) r_state <= ST_STREAM;
          else r_gap_cnt <= r_gap_cnt - 1'b1;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pix = '0;
    case (r_mode)
      2'd0:    w_pix = DATA_WIDTH'(r_lfsr);
      2'd1:    w_pix = DATA_WIDTH'(r_col);
      2'd2:    w_pix = DATA_WIDTH'(r_row);
      default: w_pix = DATA_WIDTH'(CONST_VALUE);
    endcase
  end

  // Data and markers are gated by valid so idle outputs read as zero.
  assign pixel_out   = w_valid ? w_pix : '0;
  assign pixel_valid = w_valid;
  assign sof         = w_valid && (r_col == '0) && (r_row == '0);
  assign eol         = w_valid && w_eol;
  assign eof         = w_valid && w_eof;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Randomized self-checking bench for pixel_stream_gen against a beat-indexed reference model.
module tb_pixel_stream_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned NF = 2;
  localparam int unsigned TOTAL = W * H * NF;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] CVAL = 16'h005A;
`ifdef PIXEL_GEN_LINE_GAP_EN
  localparam int unsigned GAPC = 3;
`else
  localparam int unsigned GAPC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          pixel_ready = 1'b0;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid, sof, eol, eof, busy, done;
  logic [15:0]   frame_count;

  int n_checks = 0;
  int n_errors = 0;

  pixel_stream_gen #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .NUM_FRAMES  (NF),
    .LFSR_SEED   (SEED),
    .CONST_VALUE (CVAL),
    .GAP_CYCLES  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .pixel_out  (pixel_out),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof),
    .busy       (busy),
    .done       (done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Runs one start from the current negedge; stops early after abort_at transfers.
  task automatic run(input logic [1:0] m, input bit rnd, input int abort_at);
    int k = 0;
    int gap = 0;
    int cyc = 0;
    logic [15:0] lf = SEED;
    int col, row;
    logic [DW-1:0] exp_d;
    bit ev, rdy;
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    check("done_low_after_start", done, 0);
    while (k < TOTAL && k < abort_at && cyc < 2000) begin
      ev  = (gap == 0);
      col = k % W;
      row = (k / W) % H;
      check("valid", pixel_valid, ev);
      check("busy", busy, 1);
      check("frame_count_mid", frame_count, k / (W * H));
      if (ev) begin
        case (m)
          2'd0:    exp_d = lf[DW-1:0];
          2'd1:    exp_d = DW'(col);
          2'd2:    exp_d = DW'(row);
          default: exp_d = CVAL[DW-1:0];
        endcase
        check("data", pixel_out, exp_d);
        check("sof", sof, (col == 0 && row == 0));
        check("eol", eol, (col == W - 1));
        check("eof", eof, (col == W - 1 && row == H - 1));
      end
      rdy = rnd ? 1'($urandom % 2) : 1'b1;
      pixel_ready = rdy;
      // Start and mode noise while busy must be ignored.
      start = rnd ? ($urandom % 4 == 0) : 1'b0;
      mode  = 2'($urandom);
      if (ev && rdy) begin
        if (col == W - 1 && k + 1 < TOTAL) gap = GAPC;
        lf = lfsr_step(lf);
        k++;
      end else if (!ev) begin
        gap--;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 2000) check("timeout", 1, 0);
    if (k == TOTAL) begin
      check("end_valid", pixel_valid, 0);
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_frame_count", frame_count, NF);
    end
  endtask

  initial begin
    #1;
    check("rst_valid", pixel_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", pixel_out, 0);
    check("rst_fc", frame_count, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_valid", pixel_valid, 0);
    run(2'd1, 1'b0, TOTAL);
    run(2'd0, 1'b0, TOTAL);
    run(2'd2, 1'b1, TOTAL);
    run(2'd3, 1'b1, TOTAL);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    // Abort mid-frame with reset.
    run(2'd1, 1'b0, 6);
    rst = 1'b0;
    #1;
    check("abort_valid", pixel_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", pixel_out, 0);
    check("abort_sof", sof, 0);
    check("abort_fc", frame_count, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_abort_done", done, 0);
    run(2'd0, 1'b1, TOTAL);
    for (int i = 0; i < 3; i++) run(2'($urandom), 1'b1, TOTAL);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
